// File: rtl/fpu_pkg.sv
`default_nettype none
//----------------------------------------------------------------------------
// fpu_pkg : opcodes, result flag indices, sequencer states, classifier (rev 1.0)
//----------------------------------------------------------------------------
package fpu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam int FLG_NAN    = 3;
   localparam int FLG_INF    = 2;
   localparam int FLG_ZERO   = 1;
   localparam int FLG_DENORM = 0;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

   localparam logic [7:0] EXP_MAX = 8'hFF;

   // Sign bit is irrelevant to the class, so only exponent and mantissa come in.
   function automatic logic [3:0] classify(input logic [30:0] bits);
      logic [7:0] expo;
      logic       mant_nz;
      expo     = bits[30:23];
      mant_nz  = |bits[22:0];
      classify = 4'b0000;
      classify[FLG_NAN]    = (expo == EXP_MAX) &&  mant_nz;
      classify[FLG_INF]    = (expo == EXP_MAX) && !mant_nz;
      classify[FLG_ZERO]   = (expo == 8'h00)   && !mant_nz;
      classify[FLG_DENORM] = (expo == 8'h00)   &&  mant_nz;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_res_fifo.sv
`default_nettype none
//----------------------------------------------------------------------------
// fpu_res_fifo : synchronous first-word-fall-through FIFO with count (rev 1.0)
//----------------------------------------------------------------------------
module fpu_res_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic                   head_valid,
   output logic [WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL_CNT) || do_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Head reads as zero when empty so stale storage never leaks onto the port.
   assign head_valid = (count != '0);
   assign head_data  = head_valid ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/fpu_cmd_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
// fpu_cmd_seq : one-at-a-time FPU command sequencer with result FIFO (rev 1.0)
//----------------------------------------------------------------------------
module fpu_cmd_seq
   import fpu_pkg::*;
#(
   parameter int FPU_LAT   = 2,
   parameter int RES_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [1:0]  cmd_op,
   output logic        fpu_start,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [1:0]  fpu_opcode,
   input  logic [31:0] fpu_o,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [3:0]  res_flags,
   output logic        busy,
   output logic        done,
   input  logic        clear_done,
   output logic [15:0] ops_count
);

   localparam int CW = $clog2(RES_DEPTH) + 1;
   localparam int WW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(RES_DEPTH);

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [WW-1:0] wait_cnt;
   logic [31:0]   cap_data;
   logic          ready_en;
   logic          accept;
   logic          push;
   logic [CW-1:0] fifo_count;
   logic [35:0]   head;

   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (accept) next_state = ST_ISSUE;
         ST_ISSUE:   next_state = ST_WAIT;
         ST_WAIT:    if (wait_cnt == '0) next_state = ST_CAPTURE;
         ST_CAPTURE: next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   // ready_en keeps cmd_ready low through reset and for the release edge itself.
   always_comb begin
      fpu_start = 1'b0;
      busy      = 1'b1;
      cmd_ready = 1'b0;
      push      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy      = 1'b0;
            cmd_ready = ready_en && (fifo_count < FULL_CNT);
         end
         ST_ISSUE:   fpu_start = 1'b1;
         ST_CAPTURE: push      = 1'b1;
         default:    ;
      endcase
   end

   assign accept = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fpu_a      <= '0;
         fpu_b      <= '0;
         fpu_opcode <= '0;
         wait_cnt   <= '0;
         cap_data   <= '0;
         ops_count  <= '0;
         done       <= 1'b0;
         ready_en   <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            fpu_a      <= cmd_a;
            fpu_b      <= cmd_b;
            fpu_opcode <= cmd_op;
         end
         if (state == ST_ISSUE)
            wait_cnt <= WW'(FPU_LAT - 1);
         else if ((state == ST_WAIT) && (wait_cnt != '0))
            wait_cnt <= wait_cnt - WW'(1);
         // FPU result is valid on the last WAIT cycle; hold it for the CAPTURE push.
         if ((state == ST_WAIT) && (wait_cnt == '0))
            cap_data <= fpu_o;
         ops_count <= ops_count + {15'd0, push};
         if (push)            done <= 1'b1;
         else if (clear_done) done <= 1'b0;
      end
   end

   fpu_res_fifo #(
      .WIDTH (36),
      .DEPTH (RES_DEPTH)
   ) u_res_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_data  ({cap_data, classify(cap_data[30:0])}),
      .pop        (res_ready),
      .head_valid (res_valid),
      .head_data  (head),
      .count      (fifo_count)
   );

   assign res_data  = head[35:4];
   assign res_flags = head[3:0];

endmodule
`default_nettype wire

// File: tb/tb_fpu_cmd_seq.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_fpu_cmd_seq : FPU stub, queue-based reference model, directed + random (rev 1.0)
//----------------------------------------------------------------------------
module tb_fpu_cmd_seq;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [1:0]  cmd_op = '0;
   logic        fpu_start;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [1:0]  fpu_opcode;
   logic [31:0] fpu_o;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic [3:0]  res_flags;
   logic        busy;
   logic        done;
   logic        clear_done = 1'b0;
   logic [15:0] ops_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fpu_cmd_seq #(.FPU_LAT(LAT), .RES_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .fpu_start(fpu_start),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_flags(res_flags), .busy(busy), .done(done), .clear_done(clear_done),
      .ops_count(ops_count)
   );

   // Stand-in FPU: fixed results for the named cases, a scrambled value otherwise.
   function automatic logic [31:0] fpu_func(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
      logic [31:0] h;
      case ({op, a, b})
         {2'b00, 32'h3F800000, 32'h40000000}: return 32'h40400000;
         {2'b10, 32'h40000000, 32'h40400000}: return 32'h40C00000;
         {2'b11, 32'h3F800000, 32'h00000000}: return 32'h7F800000;
         {2'b01, 32'h7F800000, 32'h7F800000}: return 32'h7F800001;
         {2'b00, 32'h3F800000, 32'hBF800000}: return 32'h00000000;
         default: ;
      endcase
      h = (a * 32'h9E3779B1) ^ {b[7:0], b[31:8]} ^ ({30'd0, op} * 32'h85EBCA6B);
      case (h[31:29])
         3'd0:    h[30:23] = 8'hFF;
         3'd1:    h[30:23] = 8'h00;
         default: ;
      endcase
      if (h[28] && h[27]) h[22:0] = '0;
      return h;
   endfunction

   logic [31:0] stage1, stage2;
   always @(posedge clk) begin
      if (!rst) begin
         stage1 <= '0;
         stage2 <= '0;
      end else begin
         stage1 <= fpu_start ? fpu_func(fpu_a, fpu_b, fpu_opcode) : 32'hDEADBEEF;
         stage2 <= stage1;
      end
   end
   assign fpu_o = stage2;

   function automatic logic [3:0] ref_flags(input logic [31:0] v);
      int e;
      int m;
      e = int'(v[30:23]);
      m = int'(v[22:0]);
      return {e == 255 && m != 0, e == 255 && m == 0, e == 0 && m == 0, e == 0 && m != 0};
   endfunction

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: t counts cycles since the accepting edge, 0 when idle.
   int          t = 0;
   logic [35:0] q[$];
   logic        m_done = 1'b0;
   logic [15:0] m_ops = '0;
   logic [31:0] m_a = '0, m_b = '0;
   logic [1:0]  m_op = '0;
   logic        m_rdy = 1'b0;
   logic        started = 1'b0;

   function automatic logic m_cmd_ready();
      return m_rdy && (t == 0) && (q.size() < DEPTH);
   endfunction

   always @(posedge clk) begin
      logic acc, pop, push;
      started = 1'b1;
      if (!rst) begin
         t = 0; q.delete(); m_done = 1'b0; m_ops = '0;
         m_a = '0; m_b = '0; m_op = '0; m_rdy = 1'b0;
      end else begin
         acc  = cmd_valid && m_cmd_ready();
         pop  = res_ready && (q.size() > 0);
         push = (t == LAT + 2);
         if (pop) void'(q.pop_front());
         if (push) begin
            q.push_back({fpu_func(m_a, m_b, m_op), ref_flags(fpu_func(m_a, m_b, m_op))});
            m_ops = m_ops + 16'd1;
            m_done = 1'b1;
         end else if (clear_done) begin
            m_done = 1'b0;
         end
         if (acc) begin
            m_a = cmd_a; m_b = cmd_b; m_op = cmd_op; t = 1;
         end else if (push) t = 0;
         else if (t > 0) t = t + 1;
         m_rdy = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("cmd_ready",  32'(cmd_ready),  32'(m_cmd_ready()));
         check("fpu_start",  32'(fpu_start),  32'(t == 1));
         check("busy",       32'(busy),       32'(t != 0));
         check("fpu_a",      fpu_a,           m_a);
         check("fpu_b",      fpu_b,           m_b);
         check("fpu_opcode", 32'(fpu_opcode), 32'(m_op));
         check("res_valid",  32'(res_valid),  32'(q.size() > 0));
         check("res_data",   res_data,        (q.size() > 0) ? q[0][35:4] : 32'd0);
         check("res_flags",  32'(res_flags),  (q.size() > 0) ? 32'(q[0][3:0]) : 32'd0);
         check("done",       32'(done),       32'(m_done));
         check("ops_count",  32'(ops_count),  32'(m_ops));
      end
   end

   // Called at a negedge; returns at the negedge in cycle E+1 after the accepting edge E.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      int n;
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         tests++; fails++;
         $display("FAIL accept_timeout: got cmd_ready=0 for 40 cycles, expected 1");
      end
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic pop_one();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] exp_data, input logic [3:0] exp_flags);
      send(a, b, op);
      check("lit_start_e1", 32'(fpu_start), 32'd1);
      @(negedge clk);
      check("lit_start_e2", 32'(fpu_start), 32'd0);
      repeat (2) @(negedge clk);
      check("lit_valid_e4", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("lit_valid_e5", 32'(res_valid), 32'd1);
      check("lit_data",     res_data,       exp_data);
      check("lit_flags",    32'(res_flags), 32'(exp_flags));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("lit_ready_in_reset", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("lit_ready_after_release", 32'(cmd_ready), 32'd1);

      run_one(32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 4'b0000);
      check("lit_ops_first", 32'(ops_count), 32'd1);
      check("lit_done_first", 32'(done), 32'd1);
      pop_one();
      run_one(32'h40000000, 32'h40400000, 2'b10, 32'h40C00000, 4'b0000);
      pop_one();
      run_one(32'h3F800000, 32'h00000000, 2'b11, 32'h7F800000, 4'b0100);
      pop_one();
      run_one(32'h7F800000, 32'h7F800000, 2'b01, 32'h7F800001, 4'b1000);
      pop_one();
      run_one(32'h3F800000, 32'hBF800000, 2'b00, 32'h00000000, 4'b0010);
      pop_one();

      // Fill the FIFO with the result port stalled.
      for (int i = 0; i < 4; i++) send($urandom(), $urandom(), 2'($urandom_range(3)));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("lit_ready_full", 32'(cmd_ready), 32'd0);
      end
      pop_one();
      send(32'h12345678, 32'h9ABCDEF0, 2'b10);
      repeat (3) @(negedge clk);
      pop_one();
      check("lit_valid_after_pushpop", 32'(res_valid), 32'd1);
      res_ready = 1'b1;
      repeat (6) @(negedge clk);
      res_ready = 1'b0;

      // Reset during WAIT.
      send(32'h3F800000, 32'h40000000, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("lit_rst_busy",  32'(busy),      32'd0);
      check("lit_rst_start", 32'(fpu_start), 32'd0);
      check("lit_rst_a",     fpu_a,          32'd0);
      check("lit_rst_done",  32'(done),      32'd0);
      check("lit_rst_ops",   32'(ops_count), 32'd0);
      check("lit_rst_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("lit_rst_ready_rel", 32'(cmd_ready), 32'd1);
      repeat (5) @(negedge clk);
      check("lit_rst_no_push", 32'(res_valid), 32'd0);

      // clear_done coinciding with CAPTURE loses to the set.
      send(32'h40000000, 32'h40400000, 2'b10);
      repeat (3) @(negedge clk);
      clear_done = 1'b1;
      @(negedge clk);
      clear_done = 1'b0;
      check("lit_done_set_wins", 32'(done), 32'd1);
      clear_done = 1'b1;
      @(negedge clk);
      clear_done = 1'b0;
      check("lit_done_cleared", 32'(done), 32'd0);
      pop_one();

      // Counter wrap from 0xFFFF.
      #2;
      force dut.ops_count = 16'hFFFF;
      m_ops = 16'hFFFF;
      @(negedge clk);
      #2;
      release dut.ops_count;
      @(negedge clk);
      send(32'h3F800000, 32'h40000000, 2'b00);
      repeat (4) @(negedge clk);
      check("lit_ops_wrap", 32'(ops_count), 32'd0);
      pop_one();

      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         rst        = ($urandom_range(199) != 0);
         cmd_valid  = 1'($urandom_range(1));
         cmd_a      = $urandom();
         cmd_b      = $urandom();
         cmd_op     = 2'($urandom_range(3));
         res_ready  = ($urandom_range(2) == 0);
         clear_done = ($urandom_range(15) == 0);
      end
      @(negedge clk);
      cmd_valid = 1'b0; res_ready = 1'b0; clear_done = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fpu_cmd_seq.md
# fpu_cmd_seq

Command sequencer and result buffer placed directly upstream of `FPU`, between the AXI-Lite register file and the arithmetic core. It accepts one operation at a time over a valid/ready handshake and drives the FPU's `start`/`A`/`B`/`opcode` inputs. It waits the FPU's fixed latency, captures `O`, classifies the result, and queues it in a small FIFO that software drains through a valid/ready result port.

## Interface
- `FPU_LAT`, 2: edges after the `fpu_start` cycle at which `fpu_o` is sampled. The `FPU` core requires 2.
- `RES_DEPTH`, 4: result FIFO depth. Must be a power of two, at least 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_a`, `cmd_b`  in  32  IEEE-754 single-precision operands.
- `cmd_op`  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `fpu_start`  out  1  one-cycle start pulse to FPU.
- `fpu_a`, `fpu_b`  out  32  operands to FPU.
- `fpu_opcode`  out  2  opcode to FPU.
- `fpu_o`  in  32  FPU result.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  pops the head when high together with `res_valid`.
- `res_data`  out  32  head result.
- `res_flags`  out  4  head flags `{nan, inf, zero, denorm}`.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  sticky flag, set on every FIFO push.
- `clear_done`  in  1  pulse that clears `done`.
- `ops_count`  out  16  completed-operation counter.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - `cmd_ready = (state==IDLE) && (fifo_count < RES_DEPTH)`.
  - On handshake, register a/b/op into `fpu_a`/`fpu_b`/`fpu_opcode` and go to ISSUE.
- ISSUE: `fpu_start=1` for exactly this cycle. Load `wait_cnt = FPU_LAT-1`, go to WAIT.
- WAIT: decrement `wait_cnt`. At 0, go to CAPTURE.
- CAPTURE:
  - Push `{fpu_o, flags}` into the FIFO.
  - Increment `ops_count`; it wraps 0xFFFF→0x0000.
  - Set `done`, return to IDLE.
- FIFO space is checked at accept time, and only one operation is in flight, so a push never overflows.
- `fpu_a`/`fpu_b`/`fpu_opcode` hold their value from accept until the next accept.
- Flags, computed from `fpu_o`:
  - `nan`: exp==0xFF, mant!=0.
  - `inf`: exp==0xFF, mant==0.
  - `zero`: exp==0, mant==0.
  - `denorm`: exp==0, mant!=0.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged. Pop on an empty FIFO is ignored.
- `done`: a set in the same cycle as `clear_done` wins.

## Timing
- Command accepted at edge E:
  - `fpu_start` is high in cycle E+1.
  - `fpu_o` is sampled at the edge ending cycle E+1+FPU_LAT.
  - `res_valid` rises in cycle E+FPU_LAT+3, i.e. E+5 with default `FPU_LAT` = 2.
- Next command can be accepted at the edge ending the first IDLE cycle after CAPTURE.
- Throughput: one operation per FPU_LAT+3 cycles.
- `res_data`/`res_flags` are stable while `res_valid && !res_ready`.
- Reset values (rst==0 at an edge):
  - state IDLE, FIFO empty.
  - `cmd_ready`=0 during reset, 1 the cycle after reset is released.
  - `fpu_start`=0, `fpu_a`=`fpu_b`=0, `fpu_opcode`=0.
  - `res_valid`=0, `res_data`=0, `res_flags`=0.
  - `busy`=0, `done`=0, `ops_count`=0.
- Reset mid-operation: the in-flight operation is discarded and no push occurs. The FPU shares `rst` and is cleared too.

## Structure
- Package `fpu_pkg`:
  - opcode constants `OP_ADD`/`OP_SUB`/`OP_MUL`/`OP_DIV`.
  - flag bit indices `FLG_NAN`/`FLG_INF`/`FLG_ZERO`/`FLG_DENORM`.
  - FSM state encoding.
  - `EXP_MAX` = 8'hFF.
- Sub-module `fpu_res_fifo`: 36-bit wide, `RES_DEPTH` deep, synchronous FIFO with count output and first-word-fall-through head.

## Test plan
- ADD `0x3F800000` + `0x40000000` accepted at edge E:
  - `fpu_start` high only in cycle E+1.
  - `res_valid` in cycle E+5, `res_data` = `0x40400000`, flags = 0000.
  - `ops_count` = 1, `done` = 1.
- MUL `0x40000000` × `0x40400000` → `0x40C00000`. DIV `0x3F800000` / `0x00000000` → `0x7F800000`, flags = 0100.
- SUB `0x7F800000` − `0x7F800000` → `0x7F800001`, flags = 1000. ADD `0x3F800000` + `0xBF800000` → zero flag set.
- `res_ready`=0 while issuing 5 back-to-back commands:
  - 4 are accepted, then `cmd_ready` stays 0.
  - Pop one: the 5th is accepted, results drain in order.
  - Simultaneous push and pop keeps the count at 4.
- Drive `rst`=0 in a WAIT cycle:
  - all outputs return to reset values next cycle, no result is pushed.
  - `cmd_ready`=1 one cycle after release.
- `clear_done` pulsed in the same cycle as CAPTURE → `done` stays 1. Preload `ops_count`=0xFFFF via 65535 operations (or force), one more → 0x0000.
